// File: rtl/cpu_control_fsm_if.sv
// Fetch handshake and data-memory bus between the multi-cycle control unit and the core.
interface cpu_control_fsm_if;
   // instr moves on a rising edge with instr_valid && instr_ready; mem_req, mem_we and
   // mem_size stay stable from the first MEM cycle until the edge where mem_ack is high.
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        mem_req;
   logic        mem_we;
   logic [2:0]  mem_size;
   logic        mem_ack;

   modport master (
      input  instr, instr_valid, mem_ack,
      output instr_ready, mem_req, mem_we, mem_size
   );

   modport slave (
      output instr, instr_valid, mem_ack,
      input  instr_ready, mem_req, mem_we, mem_size
   );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing for OP-IMM, OP, LUI, LOAD, STORE.
module cpu_control_fsm #(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cpu_control_fsm_if.master    bus,
   output logic [XLEN-1:0]      imm,
   output logic [4:0]           rs1,
   output logic [4:0]           rs2,
   output logic [4:0]           rd,
   output logic [2:0]           alu_op,
   output logic                 alu_alt,
   output logic                 alu_src_imm,
   output logic                 alu_a_zero,
   output logic                 alu_en,
   output logic                 rf_we,
   output logic                 retire,
   output logic                 trap,
   output logic [1:0]           trap_cause,
   output logic [CNT_W-1:0]     instret,
   output logic [2:0]           dbg_state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] MEM_LAST = CW'(MEM_TIMEOUT - 1);

   state_t          state, state_nx;
   logic [31:0]     instr_q;
   logic [CW-1:0]   mem_cnt;
   logic            is_load, is_store;
   logic            retire_nx;

   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;

   logic            dec_illegal, dec_load, dec_store;
   logic            dec_alt, dec_src_imm, dec_a_zero;
   logic [2:0]      dec_alu_op;
   logic [XLEN-1:0] dec_imm;

   assign opcode = instr_q[6:0];
   assign funct3 = instr_q[14:12];
   assign funct7 = instr_q[31:25];

   // Decode works only from the latched instruction, so no instr-to-output path exists.
   always_comb begin
      dec_illegal = 1'b0;
      dec_load    = 1'b0;
      dec_store   = 1'b0;
      dec_alt     = 1'b0;
      dec_src_imm = 1'b1;
      dec_a_zero  = 1'b0;
      dec_alu_op  = 3'b000;
      dec_imm     = '0;
      case (opcode)
         OPC_OP_IMM: begin
            dec_imm    = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
            dec_alu_op = funct3;
            dec_alt    = (funct3 == 3'b101) && instr_q[30];
            if (funct3 == 3'b001 && funct7 != F7_ZERO)
               dec_illegal = 1'b1;
            if (funct3 == 3'b101 && funct7 != F7_ZERO && funct7 != F7_ALT)
               dec_illegal = 1'b1;
         end
         OPC_OP: begin
            dec_src_imm = 1'b0;
            dec_alu_op  = funct3;
            dec_alt     = instr_q[30];
            if (funct7 != F7_ZERO && funct7 != F7_ALT)
               dec_illegal = 1'b1;
            if (funct7 == F7_ALT && funct3 != 3'b000 && funct3 != 3'b101)
               dec_illegal = 1'b1;
         end
         OPC_LUI: begin
            dec_imm    = {{(XLEN-31){instr_q[31]}}, instr_q[30:12], 12'b0};
            dec_a_zero = 1'b1;
         end
         OPC_LOAD: begin
            dec_imm  = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
            dec_load = 1'b1;
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
               dec_illegal = 1'b1;
         end
         OPC_STORE: begin
            dec_imm   = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            dec_store = 1'b1;
            if (funct3 > 3'b010)
               dec_illegal = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_nx        = state;
      bus.instr_ready = 1'b0;
      bus.mem_req     = 1'b0;
      bus.mem_we      = 1'b0;
      alu_en          = 1'b0;
      rf_we           = 1'b0;
      trap            = 1'b0;
      dbg_state       = state;
      unique case (state)
         S_FETCH: begin
            bus.instr_ready = 1'b1;
            if (bus.instr_valid)
               state_nx = S_DECODE;
         end
         S_DECODE: state_nx = dec_illegal ? S_TRAP : S_EXEC;
         S_EXEC: begin
            alu_en   = 1'b1;
            state_nx = (is_load || is_store) ? S_MEM : S_WB;
         end
         S_MEM: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = is_store;
            // A late ack on the final allowed cycle still completes the access.
            if (bus.mem_ack)
               state_nx = is_load ? S_WB : S_FETCH;
            else if (mem_cnt == MEM_LAST)
               state_nx = S_TRAP;
         end
         S_WB: begin
            rf_we    = (rd != 5'd0);
            state_nx = S_FETCH;
         end
         S_TRAP: trap = 1'b1;
         default: state_nx = S_FETCH;
      endcase
   end

   // Loads and ALU ops retire in WB; stores retire in the cycle they return to FETCH.
   assign retire_nx = (state_nx == S_WB) || (state == S_MEM && bus.mem_ack && is_store);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_FETCH;
         instr_q      <= '0;
         mem_cnt      <= '0;
         is_load      <= 1'b0;
         is_store     <= 1'b0;
         imm          <= '0;
         rs1          <= '0;
         rs2          <= '0;
         rd           <= '0;
         alu_op       <= '0;
         alu_alt      <= 1'b0;
         alu_src_imm  <= 1'b0;
         alu_a_zero   <= 1'b0;
         bus.mem_size <= '0;
         retire       <= 1'b0;
         trap_cause   <= '0;
         instret      <= '0;
      end else begin
         state  <= state_nx;
         retire <= retire_nx;
         if (retire_nx)
            instret <= instret + CNT_W'(1);
         if (state == S_FETCH && bus.instr_valid)
            instr_q <= bus.instr;
         if (state == S_DECODE) begin
            imm          <= dec_imm;
            rs1          <= instr_q[19:15];
            rs2          <= instr_q[24:20];
            rd           <= instr_q[11:7];
            alu_op       <= dec_alu_op;
            alu_alt      <= dec_alt;
            alu_src_imm  <= dec_src_imm;
            alu_a_zero   <= dec_a_zero;
            is_load      <= dec_load;
            is_store     <= dec_store;
            bus.mem_size <= (dec_load || dec_store) ? funct3 : 3'b000;
            if (dec_illegal)
               trap_cause <= 2'd1;
         end
         if (state == S_EXEC)
            mem_cnt <= '0;
         else if (state == S_MEM && !bus.mem_ack) begin
            mem_cnt <= mem_cnt + CW'(1);
            if (mem_cnt == MEM_LAST)
               trap_cause <= 2'd2;
         end
      end
   end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed and random instructions against a rule-based decode model.
module tb_cpu_control_fsm;

   localparam int MEM_TIMEOUT = 4;
   localparam logic [1:0] C_ALU = 2'd0, C_LOAD = 2'd1, C_STORE = 2'd2, C_ILL = 2'd3;

   typedef struct packed {
      logic [1:0]  cls;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  alu_op;
      logic        alu_alt;
      logic        src_imm;
      logic        a_zero;
      logic [2:0]  size;
   } exp_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cpu_control_fsm_if bus ();

   logic [31:0] imm;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  alu_op;
   logic        alu_alt, alu_src_imm, alu_a_zero, alu_en, rf_we, retire, trap;
   logic [1:0]  trap_cause;
   logic [31:0] instret;
   logic [2:0]  dbg_state;

   cpu_control_fsm #(.XLEN(32), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .imm         (imm),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .alu_op      (alu_op),
      .alu_alt     (alu_alt),
      .alu_src_imm (alu_src_imm),
      .alu_a_zero  (alu_a_zero),
      .alu_en      (alu_en),
      .rf_we       (rf_we),
      .retire      (retire),
      .trap        (trap),
      .trap_cause  (trap_cause),
      .instret     (instret),
      .dbg_state   (dbg_state)
   );

   // scoreboard
   logic [36:0] exp_q[$];
   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int instret_m = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: decode rules written as arithmetic on the instruction word
   function automatic exp_t model(input logic [31:0] ins);
      exp_t e;
      int unsigned op, f3, f7;
      int v;
      e = '0;
      op = ins & 32'h7f;
      f3 = (ins >> 12) & 32'h7;
      f7 = ins >> 25;
      e.rd      = 5'((ins >> 7) & 32'h1f);
      e.rs1     = 5'((ins >> 15) & 32'h1f);
      e.rs2     = 5'((ins >> 20) & 32'h1f);
      e.src_imm = 1'b1;
      e.cls     = C_ALU;
      v = int'(ins >> 20);
      if (v >= 2048) v = v - 4096;
      case (op)
         32'h13: begin
            e.imm = 32'(v);
            e.alu_op = 3'(f3);
            e.alu_alt = (f3 == 5) ? 1'((ins >> 30) & 1) : 1'b0;
            if (f3 == 1 && f7 != 0) e.cls = C_ILL;
            if (f3 == 5 && f7 != 0 && f7 != 32) e.cls = C_ILL;
         end
         32'h33: begin
            e.src_imm = 1'b0;
            e.alu_op = 3'(f3);
            e.alu_alt = 1'((ins >> 30) & 1);
            if (f7 != 0 && f7 != 32) e.cls = C_ILL;
            if (f7 == 32 && f3 != 0 && f3 != 5) e.cls = C_ILL;
         end
         32'h37: begin
            e.imm = ins & 32'hFFFF_F000;
            e.a_zero = 1'b1;
         end
         32'h03: begin
            e.imm = 32'(v);
            e.cls = (f3 == 3 || f3 == 6 || f3 == 7) ? C_ILL : C_LOAD;
            e.size = 3'(f3);
         end
         32'h23: begin
            v = int'(f7 * 32 + ((ins >> 7) & 32'h1f));
            if (v >= 2048) v = v - 4096;
            e.imm = 32'(v);
            e.cls = (f3 > 2) ? C_ILL : C_STORE;
            e.size = 3'(f3);
         end
         default: e.cls = C_ILL;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] gen_legal();
      logic [31:0] r;
      int k, f3, f7;
      int lf[5] = '{0, 1, 2, 4, 5};
      r  = $urandom();
      k  = $urandom_range(0, 4);
      f3 = $urandom_range(0, 7);
      if ($urandom_range(0, 5) == 0) r[11:7] = 5'd0;
      case (k)
         0: begin
            if (f3 == 1) f7 = 0;
            else if (f3 == 5) f7 = $urandom_range(0, 1) * 32;
            else f7 = int'(r[31:25]);
            r = {7'(f7), r[24:15], 3'(f3), r[11:7], 7'h13};
         end
         1: begin
            f7 = $urandom_range(0, 1) * 32;
            if (f7 == 32) f3 = $urandom_range(0, 1) * 5;
            r = {7'(f7), r[24:15], 3'(f3), r[11:7], 7'h33};
         end
         2: r = {r[31:7], 7'h37};
         3: r = {r[31:15], 3'(lf[$urandom_range(0, 4)]), r[11:7], 7'h03};
         default: r = {r[31:15], 3'($urandom_range(0, 2)), r[11:7], 7'h23};
      endcase
      return r;
   endfunction

   // driver tasks
   task automatic do_reset();
      bus.instr_valid = 1'b0;
      bus.mem_ack     = 1'b0;
      bus.instr       = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      instret_m = 0;
   endtask

   task automatic wait_ready();
      int g;
      g = 0;
      @(negedge clk);
      while (!bus.instr_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("ready_wait", bus.instr_ready, 1);
   endtask

   task automatic hold_trap(input logic [1:0] cause);
      int bad;
      logic [2:0] st0;
      bad = 0;
      st0 = dbg_state;
      bus.instr_valid = 1'b1;
      bus.instr = 32'h0000_0013;
      repeat (6) begin
         @(negedge clk);
         if (bus.instr_ready !== 1'b0 || trap !== 1'b1 || trap_cause !== cause ||
             rf_we !== 1'b0 || bus.mem_req !== 1'b0 || alu_en !== 1'b0 ||
             retire !== 1'b0 || dbg_state !== st0)
            bad++;
      end
      check("trap_hold", bad, 0);
      do_reset();
   endtask

   task automatic run_instr(input logic [31:0] ins, input int ack_wait);
      exp_t e;
      int cyc, rf_n, rf_cyc, ret_n, req_n, ready_cyc, we_bad;
      logic we_first;
      logic [2:0] size_first;
      logic [36:0] exp_e;
      logic expect_tmo;
      e = model(ins);
      expect_tmo = (e.cls == C_LOAD || e.cls == C_STORE) && (ack_wait >= MEM_TIMEOUT);
      if (e.cls != C_ILL) exp_q.push_back({e.rd, e.imm});
      wait_ready();
      bus.instr = ins;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.instr = $urandom();
      cyc = 0; rf_n = 0; rf_cyc = 0; ret_n = 0; req_n = 0; ready_cyc = 0; we_bad = 0;
      we_first = 1'b0;
      size_first = 3'b000;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 2 && e.cls != C_ILL && exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check("dec_rd_imm", {rd, imm}, exp_e);
            check("dec_rs", {rs1, rs2}, {e.rs1, e.rs2});
            check("dec_alu", {alu_op, alu_alt, alu_src_imm, alu_a_zero, alu_en},
                  {e.alu_op, e.alu_alt, e.src_imm, e.a_zero, 1'b1});
         end
         if (bus.mem_req) begin
            req_n++;
            if (req_n == 1) begin
               we_first = bus.mem_we;
               size_first = bus.mem_size;
            end else if (bus.mem_we !== we_first || bus.mem_size !== size_first)
               we_bad++;
         end
         if (rf_we) begin
            rf_n++;
            rf_cyc = cyc;
         end
         if (retire) ret_n++;
         bus.mem_ack = bus.mem_req && (req_n == ack_wait + 1);
         if (bus.instr_ready) begin
            ready_cyc = cyc;
            break;
         end
         if (trap) break;
      end
      bus.mem_ack = 1'b0;

      if (e.cls == C_ILL) begin
         check("ill_trap", {trap, trap_cause}, {1'b1, 2'd1});
         check("ill_cycle", cyc, 2);
         check("ill_quiet", rf_n + ret_n + req_n, 0);
         hold_trap(2'd1);
      end else if (expect_tmo) begin
         check("tmo_trap", {trap, trap_cause}, {1'b1, 2'd2});
         check("tmo_req_cycles", req_n, MEM_TIMEOUT);
         check("tmo_quiet", rf_n + ret_n, 0);
         hold_trap(2'd2);
      end else begin
         instret_m++;
         check("retire_count", ret_n, 1);
         check("instret", instret, 32'(instret_m));
         check("no_trap", trap, 0);
         case (e.cls)
            C_ALU: begin
               check("alu_rf_we_n", rf_n, (e.rd != 0) ? 1 : 0);
               check("alu_rf_we_cyc", rf_cyc, (e.rd != 0) ? 3 : 0);
               check("alu_no_mem", req_n, 0);
               check("alu_ready_cyc", ready_cyc, 4);
            end
            C_LOAD: begin
               check("ld_rf_we_n", rf_n, (e.rd != 0) ? 1 : 0);
               check("ld_rf_we_cyc", rf_cyc, (e.rd != 0) ? 4 + ack_wait : 0);
               check("ld_req_cycles", req_n, ack_wait + 1);
               check("ld_bus", {we_first, size_first}, {1'b0, e.size});
               check("ld_stable", we_bad, 0);
               check("ld_ready_cyc", ready_cyc, 5 + ack_wait);
            end
            default: begin
               check("st_no_rf_we", rf_n, 0);
               check("st_req_cycles", req_n, ack_wait + 1);
               check("st_bus", {we_first, size_first}, {1'b1, e.size});
               check("st_stable", we_bad, 0);
               check("st_ready_cyc", ready_cyc, 4 + ack_wait);
            end
         endcase
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ill_list[7];
      ill_list = '{32'h0000_007F, 32'h0220_8133, 32'h4020_9133, 32'h0200_9093,
                   32'hC000_D093, 32'h0000_B003, 32'h0000_B023};

      // reset state, checked while rst_n is still low
      bus.instr_valid = 1'b0;
      bus.mem_ack = 1'b0;
      bus.instr = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", bus.instr_ready, 1);
      check("rst_dec", {imm, rs1, rs2, rd, alu_op, alu_alt, alu_src_imm, alu_a_zero}, 0);
      check("rst_ctl", {alu_en, bus.mem_req, bus.mem_we, bus.mem_size, rf_we, retire, trap, trap_cause}, 0);
      check("rst_instret", instret, 0);
      rst_n = 1'b1;

      // directed instructions
      run_instr(32'hFFF0_8293, 0);   // ADDI x5,x1,-1
      run_instr(32'h4020_81B3, 0);   // SUB x3,x1,x2
      run_instr(32'h4032_5213, 0);   // SRAI x4,x4,3
      run_instr(32'h0081_2303, 3);   // LW x6,8(x2), ack on the last allowed cycle
      run_instr(32'hFE61_2E23, 0);   // SW x6,-4(x2)
      run_instr(32'h0000_0013, 0);   // NOP
      run_instr(32'h8000_0537, 0);   // LUI x10,0x80000

      for (int i = 0; i < 40; i++)
         run_instr(gen_legal(), $urandom_range(0, MEM_TIMEOUT - 1));

      // reset while a load sits in MEM
      wait_ready();
      bus.instr = 32'h0081_2303;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_mem_req", bus.mem_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", {bus.instr_ready, bus.mem_req}, {1'b1, 1'b0});
      check("mid_rst_quiet", {rf_we, retire, trap}, 0);
      check("mid_rst_instret", instret, 0);
      @(negedge clk);
      rst_n = 1'b1;
      instret_m = 0;
      run_instr(32'h0081_2303, 1);
      run_instr(32'h0050_0093, 0);   // ADDI x1,x0,5

      // illegal encodings, each followed by reset
      foreach (ill_list[i])
         run_instr(ill_list[i], 0);

      // memory timeout
      run_instr(32'h0081_2303, 100);
      run_instr(32'hFE61_2E23, 100);

      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control unit for the second-generation CPU core. It replaces the single-cycle OP-IMM-only decoder. It accepts one instruction at a time from fetch through a valid/ready handshake and decodes OP-IMM, OP, LUI, LOAD and STORE. It sequences FETCH/DECODE/EXEC/MEM/WB, drives registered register-file, ALU and data-memory controls, traps on illegal encodings or memory timeout, and counts retired instructions.

Parameters:
XLEN, 32, datapath width; immediate is sign-extended to XLEN; legal values are 32 or greater.
MEM_TIMEOUT, 255, maximum MEM-state cycles without mem_ack before trap; minimum 1.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr  in  32  instruction from fetch.
instr_valid  in  1  instr is valid.
instr_ready  out  1  control can accept an instruction.
imm  out  XLEN  decoded, sign-extended immediate.
rs1  out  5  source register 1 index.
rs2  out  5  source register 2 index.
rd  out  5  destination register index.
alu_op  out  3  ALU operation; equals funct3 for arithmetic instructions.
alu_alt  out  1  SUB/SRA select.
alu_src_imm  out  1  ALU operand B = imm.
alu_a_zero  out  1  ALU operand A = 0 (LUI).
alu_en  out  1  ALU result capture strobe.
mem_req  out  1  data-memory request.
mem_we  out  1  store when 1, load when 0.
mem_size  out  3  funct3 of the load/store.
mem_ack  in  1  memory completes the request.
rf_we  out  1  register-file write enable.
retire  out  1  one-cycle pulse per completed instruction.
trap  out  1  sticky error flag.
trap_cause  out  2  1 = illegal instruction, 2 = memory timeout.
instret  out  CNT_W  retired-instruction count.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs are registered or decoded from state only; no combinational path from instr to any output.
- Reset (async, rst_n=0):
  - state=FETCH.
  - All outputs 0 except instr_ready=1.
  - instret=0, MEM counter=0, trap cleared.
  - Reset mid-instruction abandons the instruction with no rf_we or retire.
- FETCH:
  - instr_ready=1.
  - If instr_valid is high at a rising edge, latch instr and go to DECODE; otherwise stay.
  - instr_ready is 0 in every other state.
- DECODE (1 cycle): register imm, rs1, rs2, rd, alu_*, mem_size.
  - Go to TRAP with cause 1 on an illegal encoding:
    - unknown opcode;
    - OP with funct7 not in {0000000, 0100000};
    - OP with funct7=0100000 and funct3 not in {000, 101};
    - OP-IMM funct3=001 with instr[31:25]≠0;
    - OP-IMM funct3=101 with instr[31:25] not in {0000000, 0100000};
    - LOAD funct3 in {011, 110, 111};
    - STORE funct3 > 010.
  - Otherwise go to EXEC.
- Immediate formats:
  - OP-IMM/LOAD use I-type: instr[31:20].
  - STORE uses S-type: {instr[31:25], instr[11:7]}.
  - I-type and S-type are sign-extended from bit 31.
  - LUI uses U-type: {instr[31:12], 12'b0}, sign-extended from bit 31.
  - OP: imm=0.
- ALU controls:
  - alu_op = funct3 for OP/OP-IMM; 000 otherwise.
  - alu_alt = instr[30] for OP, and for OP-IMM only when funct3=101; 0 otherwise.
  - alu_src_imm = 0 for OP only.
  - alu_a_zero = 1 for LUI only.
- EXEC (1 cycle): alu_en=1. OP/OP-IMM/LUI go to WB; LOAD/STORE go to MEM with the counter cleared.
- MEM:
  - mem_req=1, mem_we=1 for STORE; both held stable until mem_ack.
  - mem_ack seen: LOAD goes to WB; STORE goes to FETCH with retire=1 in the FETCH entry cycle.
  - Counter increments each MEM cycle without ack. When it reaches MEM_TIMEOUT, go to TRAP with cause 2.
  - mem_ack on the timeout cycle wins (no trap).
- WB (1 cycle):
  - rf_we=1 unless rd=0, which suppresses the write but still retires.
  - retire=1, then go to FETCH.
- instret increments on every retire pulse and wraps modulo 2^CNT_W.
- TRAP: terminal until reset. trap=1, trap_cause held, instr_ready=0, and rf_we/mem_req/alu_en=0.
- Latency, counted from the accept edge:
  - ALU-class instruction: rf_we is high in the 3rd cycle after accept; next accept possible 4 cycles after the previous one.
  - LOAD: 4 + (ack wait cycles).
  - STORE: 3 + (wait cycles) + next FETCH.

Test Plan:
- ADDI x5,x1,-1 (0xFFF08293), valid held high: rf_we high one cycle with rd=5, imm=0xFFFFFFFF, alu_op=000, alu_src_imm=1; retire once; instret=1; next instr_ready 4 cycles after accept.
- SUB x3,x1,x2 (0x402081B3) then SRAI x4,x4,3 (0x40325213): alu_alt=1 and alu_src_imm=0 for the first; alu_alt=1, alu_op=101, imm=0x403 for the second.
- LW x6,8(x2) with mem_ack after 3 wait cycles: mem_req high for 4 cycles, mem_we=0, mem_size=010, then rf_we one cycle. SW x6,-4(x2) (0xFE612E23): imm=0xFFFFFFFC, mem_we=1, no rf_we, retire once.
- ADDI x0,x0,0 (NOP): rf_we stays 0, retire=1, instret increments.
- Illegal opcode 0x0000007F: trap=1, trap_cause=1, instr_ready stays 0 forever; MEM_TIMEOUT=4 with mem_ack never asserted: trap_cause=2 after 4 MEM cycles.
- rst_n pulsed low during MEM of a LOAD: immediately state=FETCH, mem_req=0, instret=0, no rf_we; the next instruction decodes normally.
